// File: rtl/div_alu_if.sv
// Start/done handshake bundle shared by the execute-stage iterative units.
// The issuing stage drives the master side; the divider is the slave.
interface div_alu_if;
   logic        start;
   logic        flush;
   logic        signed_op;
   logic [31:0] reg1;
   logic [31:0] reg2;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   modport master (
      output start, flush, signed_op, reg1, reg2,
      input  busy, done, quotient, remainder
   );

   modport slave (
      input  start, flush, signed_op, reg1, reg2,
      output busy, done, quotient, remainder
   );
endinterface

// File: rtl/div_alu.sv
// Iterative 32-bit radix-2 restoring divider with sign correction, 34-cycle latency.
// Optional DIV_EARLY_OUT_EN finishes trivial divides (zero divisor, |a|<|b|) in one cycle.
module div_alu (
   input  logic       clk,
   input  logic       rst,
   div_alu_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q;
   logic [31:0] shq_q;      // dividend bits shifting out, quotient bits shifting in
   logic [31:0] prem_q;     // partial remainder
   logic [31:0] dvs_q;      // divisor magnitude
   logic [31:0] dvd_q;      // raw dividend, needed for the divide-by-zero remainder
   logic        qneg_q, rneg_q, dz_q;
   logic        done_q;
   logic [31:0] quot_q, rem_q;

   logic [31:0] abs_a, abs_b;
   logic        early_out;
   logic        launch;
   logic [32:0] rem_sh, diff;

   assign abs_a  = (bus.signed_op && bus.reg1[31]) ? (~bus.reg1 + 32'd1) : bus.reg1;
   assign abs_b  = (bus.signed_op && bus.reg2[31]) ? (~bus.reg2 + 32'd1) : bus.reg2;
   assign launch = (state_q == IDLE) && bus.start && !bus.flush;

`ifdef DIV_EARLY_OUT_EN
   assign early_out = (bus.reg2 == 32'd0) || (abs_a < abs_b);
`else
   assign early_out = 1'b0;
`endif

   assign rem_sh = {prem_q, shq_q[31]};
   assign diff   = rem_sh - {1'b0, dvs_q};

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (launch && !early_out) state_d = CALC;
         CALC:    if (cnt_q == 6'd31)       state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush) state_d = IDLE;
   end

   always_comb begin
      bus.busy      = (state_q != IDLE);
      bus.done      = done_q;
      bus.quotient  = quot_q;
      bus.remainder = rem_q;
   end

   // Control and architected results are reset; results only move on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b0;
         quot_q <= '0;
         rem_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (launch && early_out) begin
            quot_q <= (bus.reg2 == 32'd0) ? '1 : '0;
            rem_q  <= bus.reg1;
            done_q <= 1'b1;
         end else if (state_q == FIX && !bus.flush) begin
            if (dz_q) begin
               quot_q <= '1;
               rem_q  <= dvd_q;
            end else begin
               quot_q <= qneg_q ? (~shq_q + 32'd1)  : shq_q;
               rem_q  <= rneg_q ? (~prem_q + 32'd1) : prem_q;
            end
            done_q <= 1'b1;
         end
      end
   end

   // NOTE: working registers carry no reset; they are always loaded on launch before use.
   always_ff @(posedge clk) begin
      if (launch) begin
         shq_q  <= abs_a;
         prem_q <= '0;
         dvs_q  <= abs_b;
         dvd_q  <= bus.reg1;
         qneg_q <= bus.signed_op & (bus.reg1[31] ^ bus.reg2[31]);
         rneg_q <= bus.signed_op & bus.reg1[31];
         dz_q   <= (bus.reg2 == 32'd0);
         cnt_q  <= '0;
      end else if (state_q == CALC) begin
         if (!diff[32]) begin
            prem_q <= diff[31:0];
            shq_q  <= {shq_q[30:0], 1'b1};
         end else begin
            prem_q <= rem_sh[31:0];
            shq_q  <= {shq_q[30:0], 1'b0};
         end
         cnt_q <= cnt_q + 6'd1;
      end
   end

endmodule

// File: tb/tb_div_alu.sv
// Directed self-checking bench for div_alu: latency window, signed/unsigned results,
// divide-by-zero, overflow, flush abort, ignored/accepted starts and mid-divide reset.
module tb_div_alu;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_EO = 1;
`else
   localparam int LAT_EO = 34;
`endif
   localparam int LAT = 34;

   always #5 clk = ~clk;

   div_alu_if bus ();

   div_alu u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives a one-cycle start; returns positioned in cycle n+1 with operands scrambled.
   task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
      bus.signed_op = s;
      bus.reg1      = a;
      bus.reg2      = b;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      bus.signed_op = ~s;
      bus.reg1      = 32'hDEAD_BEEF;
      bus.reg2      = 32'h0000_0003;
   endtask

   // Counts cycles since the start cycle until done, bounded at 100.
   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (bus.done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic s, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                      input int elat);
      int lat;
      start_op(s, a, b);
      wait_done(1, lat);
      check({tag, " latency"}, lat, elat);
      check({tag, " quotient"}, bus.quotient, eq);
      check({tag, " remainder"}, bus.remainder, er);
      tick();
   endtask

   initial begin
      int lat;
      int bad;
      bit saw_done;

      bus.start     = 1'b0;
      bus.flush     = 1'b0;
      bus.signed_op = 1'b0;
      bus.reg1      = '0;
      bus.reg2      = '0;

      tick();
      tick();
      rst = 1'b0;
      check("reset busy", bus.busy, 0);
      check("reset done", bus.done, 0);
      check("reset quotient", bus.quotient, 0);
      check("reset remainder", bus.remainder, 0);

      // Full latency window for an unsigned divide.
      start_op(1'b0, 32'hFFFF_FFFF, 32'd2);
      bad = 0;
      for (int k = 1; k <= 33; k++) begin
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
         tick();
      end
      check("busy window n+1..n+33", bad, 0);
      check("done at n+34", bus.done, 1);
      check("busy low at n+34", bus.busy, 0);
      check("u FFFFFFFF/2 quotient", bus.quotient, 32'h7FFF_FFFF);
      check("u FFFFFFFF/2 remainder", bus.remainder, 32'd1);
      tick();
      check("done one-cycle pulse", bus.done, 0);

      run("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT);
      run("u FFFFFFF9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, LAT);
      run("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, LAT);
      run("s overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, LAT);
      run("u 5/9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, LAT_EO);
      run("s div0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, LAT_EO);
      run("s -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, LAT_EO);
      run("u div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, LAT_EO);

      // Flush in cycle n+10 aborts the divide without touching the results.
      start_op(1'b0, 32'd100, 32'd7);
      for (int k = 1; k < 10; k++) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush busy low n+11", bus.busy, 0);
      saw_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done === 1'b1) saw_done = 1'b1;
         tick();
      end
      check("flush no done", saw_done, 0);
      check("flush keeps quotient", bus.quotient, 32'hFFFF_FFFF);
      check("flush keeps remainder", bus.remainder, 32'h1234_5678);
      run("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT);

      // Flush wins over start in the same cycle.
      bus.flush = 1'b1;
      start_op(1'b0, 32'd100, 32'd7);
      bus.flush = 1'b0;
      check("flush beats start busy", bus.busy, 0);
      check("flush beats start done", bus.done, 0);
      tick();

      // Start while busy is ignored; start in the done cycle is accepted.
      start_op(1'b0, 32'd100, 32'd7);
      for (int k = 0; k < 5; k++) tick();
      start_op(1'b0, 32'd50, 32'd5);
      wait_done(7, lat);
      check("busy-start ignored latency", lat, LAT);
      check("busy-start ignored quotient", bus.quotient, 32'd14);
      check("busy-start ignored remainder", bus.remainder, 32'd2);
      start_op(1'b0, 32'd50, 32'd5);
      wait_done(1, lat);
      check("done-cycle start latency", lat, LAT);
      check("done-cycle start quotient", bus.quotient, 32'd10);
      check("done-cycle start remainder", bus.remainder, 32'd0);
      tick();

      // Reset mid-divide clears everything on the next cycle.
      start_op(1'b1, 32'd1000, 32'd3);
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      check("mid rst busy", bus.busy, 0);
      check("mid rst done", bus.done, 0);
      check("mid rst quotient", bus.quotient, 0);
      check("mid rst remainder", bus.remainder, 0);
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
